// File: rtl/dadda_product_accumulator.sv
// Multiply-accumulate back end: sums COUNT unsigned products from the Dadda
// multiplier and hands each finished sum, with a sticky overflow flag, downstream.
module dadda_product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int COUNT  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic             started;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum_ext;
  logic             last;

  assign sum_ext   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
  assign last      = (cnt == CNT_W'(COUNT - 1));
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // started delays the IDLE exit by one edge so in_ready rises on the
  // second rising edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      started      <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      started <= 1'b1;
      if (clear) begin
        state <= ACCUM;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            if (started) state <= ACCUM;
          end
          ACCUM: begin
            if (in_valid) begin
              if (last) begin
                out_sum      <= sum_ext[ACC_W-1:0];
                out_overflow <= ovf | sum_ext[ACC_W];
                state        <= HOLD;
                acc          <= '0;
                cnt          <= '0;
                ovf          <= 1'b0;
              end else begin
                acc <= sum_ext[ACC_W-1:0];
                ovf <= ovf | sum_ext[ACC_W];
                cnt <= cnt + 1'b1;
              end
            end
          end
          HOLD: begin
            if (out_ready) state <= ACCUM;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Bench for dadda_product_accumulator: three instances (COUNT 4, 20, 1)
// exercised by directed scenarios and a randomized run against a sum model.
module tb_dadda_product_accumulator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr [3];
  logic        iv  [3];
  logic        ir  [3];
  logic [7:0]  prod[3];
  logic        ov  [3];
  logic        ordy[3];
  logic [11:0] osum[3];
  logic        oovf[3];

  int checks = 0;
  int errors = 0;
  int counts[3] = '{4, 20, 1};

  always #5 clock = ~clock;

  dadda_product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(4)) u_c4 (
    .clock(clock), .reset_n(reset_n), .clear(clr[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .in_product(prod[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_sum(osum[0]), .out_overflow(oovf[0]));

  dadda_product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(20)) u_c20 (
    .clock(clock), .reset_n(reset_n), .clear(clr[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .in_product(prod[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_sum(osum[1]), .out_overflow(oovf[1]));

  dadda_product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(1)) u_c1 (
    .clock(clock), .reset_n(reset_n), .clear(clr[2]), .in_valid(iv[2]),
    .in_ready(ir[2]), .in_product(prod[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_sum(osum[2]), .out_overflow(oovf[2]));

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      clr[d] = 0; iv[d] = 0; prod[d] = 0; ordy[d] = 0;
    end
    reset_n = 0;
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ir[d], ov[d], osum[d], oovf[d]} !== 15'd0) begin
        errors++;
        $display("FAIL reset_vals d=%0d got ir=%b ov=%b sum=%0d ovf=%b exp all 0", d, ir[d], ov[d], osum[d], oovf[d]);
      end
    end
    @(posedge clock); #1;
    reset_n = 1;
    cyc();
    checks++;
    if (ir[0] !== 1'b0) begin errors++; $display("FAIL ready_edge1 got %b exp 0", ir[0]); end
    cyc();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ir[d] !== 1'b1) begin errors++; $display("FAIL ready_edge2 d=%0d got %b exp 1", d, ir[d]); end
    end
  endtask

  task automatic test_basic();
    int p[4] = '{6, 15, 225, 0};
    ordy[0] = 1;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1; prod[0] = p[i];
      cyc();
      if (i == 2) begin
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", ov[0]); end
      end
    end
    iv[0] = 0;
    checks++;
    if (ov[0] !== 1'b1 || osum[0] !== 12'd246 || oovf[0] !== 1'b0 || ir[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got ov=%b sum=%0d ovf=%b ir=%b exp 1 246 0 0", ov[0], osum[0], oovf[0], ir[0]);
    end
    cyc();
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++; $display("FAIL basic_release got ov=%b ir=%b exp 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_hold();
    int p[4] = '{6, 15, 225, 0};
    ordy[0] = 0;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1; prod[0] = p[i]; cyc();
    end
    iv[0] = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ov[0] !== 1'b1 || osum[0] !== 12'd246 || ir[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got ov=%b sum=%0d ir=%b exp 1 246 0", i, ov[0], osum[0], ir[0]);
      end
      if (i == 5) ordy[0] = 1;
      cyc();
    end
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++; $display("FAIL hold_release got ov=%b ir=%b exp 0 1", ov[0], ir[0]);
    end
    // First product offered right after the handshake must be counted.
    p = '{5, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1; prod[0] = p[i]; cyc();
    end
    iv[0] = 0;
    checks++;
    if (ov[0] !== 1'b1 || osum[0] !== 12'd8) begin
      errors++; $display("FAIL hold_next got ov=%b sum=%0d exp 1 8", ov[0], osum[0]);
    end
    cyc();
  endtask

  task automatic test_clear();
    ordy[0] = 1;
    iv[0] = 1; prod[0] = 10; cyc();
    iv[0] = 0; repeat (3) cyc();
    iv[0] = 1; prod[0] = 20; cyc();
    clr[0] = 1; prod[0] = 99; cyc();
    clr[0] = 0;
    for (int i = 1; i <= 4; i++) begin
      iv[0] = 1; prod[0] = 8'(i); cyc();
    end
    iv[0] = 0;
    checks++;
    if (ov[0] !== 1'b1 || osum[0] !== 12'd10) begin
      errors++; $display("FAIL clear_partial got ov=%b sum=%0d exp 1 10", ov[0], osum[0]);
    end
    cyc();
    ordy[0] = 0;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1; prod[0] = 50; cyc();
    end
    iv[0] = 0;
    clr[0] = 1; cyc(); clr[0] = 0;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++; $display("FAIL clear_hold got ov=%b ir=%b exp 0 1", ov[0], ir[0]);
    end
    ordy[0] = 1;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1; prod[0] = 2; cyc();
    end
    iv[0] = 0;
    checks++;
    if (ov[0] !== 1'b1 || osum[0] !== 12'd8) begin
      errors++; $display("FAIL clear_after_hold got ov=%b sum=%0d exp 1 8", ov[0], osum[0]);
    end
    cyc();
  endtask

  task automatic test_overflow();
    ordy[1] = 1;
    repeat (20) begin iv[1] = 1; prod[1] = 225; cyc(); end
    iv[1] = 0;
    checks++;
    if (ov[1] !== 1'b1 || osum[1] !== 12'd404 || oovf[1] !== 1'b1) begin
      errors++; $display("FAIL ovf_set got ov=%b sum=%0d ovf=%b exp 1 404 1", ov[1], osum[1], oovf[1]);
    end
    cyc();
    repeat (20) begin iv[1] = 1; prod[1] = 1; cyc(); end
    iv[1] = 0;
    checks++;
    if (ov[1] !== 1'b1 || osum[1] !== 12'd20 || oovf[1] !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got ov=%b sum=%0d ovf=%b exp 1 20 0", ov[1], osum[1], oovf[1]);
    end
    cyc();
  endtask

  task automatic test_count1();
    ordy[2] = 1;
    iv[2] = 1; prod[2] = 7; cyc();
    checks++;
    if (ov[2] !== 1'b1 || osum[2] !== 12'd7) begin
      errors++; $display("FAIL c1_first got ov=%b sum=%0d exp 1 7", ov[2], osum[2]);
    end
    prod[2] = 9; cyc();
    checks++;
    if (ov[2] !== 1'b0 || ir[2] !== 1'b1) begin
      errors++; $display("FAIL c1_gap got ov=%b ir=%b exp 0 1", ov[2], ir[2]);
    end
    cyc();
    checks++;
    if (ov[2] !== 1'b1 || osum[2] !== 12'd9) begin
      errors++; $display("FAIL c1_second got ov=%b sum=%0d exp 1 9", ov[2], osum[2]);
    end
    iv[2] = 0; cyc();
  endtask

  task automatic test_reset_mid();
    ordy[0] = 1;
    repeat (2) begin iv[0] = 1; prod[0] = 1; cyc(); end
    iv[0] = 0;
    reset_n = 0;
    #2;
    checks++;
    if ({ir[0], ov[0], osum[0], oovf[0]} !== 15'd0) begin
      errors++;
      $display("FAIL midreset_vals got ir=%b ov=%b sum=%0d ovf=%b exp all 0", ir[0], ov[0], osum[0], oovf[0]);
    end
    @(posedge clock); #1;
    reset_n = 1;
    cyc();
    checks++;
    if (ir[0] !== 1'b0) begin errors++; $display("FAIL midreset_edge1 got %b exp 0", ir[0]); end
    cyc();
    checks++;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL midreset_edge2 got %b exp 1", ir[0]); end
    repeat (4) begin iv[0] = 1; prod[0] = 1; cyc(); end
    iv[0] = 0;
    checks++;
    if (ov[0] !== 1'b1 || osum[0] !== 12'd4) begin
      errors++; $display("FAIL midreset_sum got ov=%b sum=%0d exp 1 4", ov[0], osum[0]);
    end
    cyc();
  endtask

  // Model: products since the last clear/result are totalled as plain
  // integers; the result is the total mod 4096, overflow iff it reached 4096.
  task automatic test_random(input int d, input int ncyc);
    int  total, n, esum;
    bit  pend, eovf, c, v, r;
    int  p;
    clr[d] = 1; iv[d] = 0; ordy[d] = 0; cyc(); clr[d] = 0;
    pend = 0; total = 0; n = 0; esum = 0; eovf = 0;
    repeat (ncyc) begin
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      p = (d == 1) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
      clr[d] = c; iv[d] = v; ordy[d] = r; prod[d] = 8'(p);
      if (c) begin
        pend = 0; total = 0; n = 0;
      end else if (pend) begin
        if (r) pend = 0;
      end else if (v) begin
        total += p; n++;
        if (n == counts[d]) begin
          pend = 1; esum = total % 4096; eovf = (total >= 4096);
          total = 0; n = 0;
        end
      end
      cyc();
      checks++;
      if (ov[d] !== pend || ir[d] !== !pend) begin
        errors++; $display("FAIL rand_hs d=%0d got ov=%b ir=%b exp %b %b", d, ov[d], ir[d], pend, !pend);
      end
      if (pend) begin
        checks++;
        if (osum[d] !== 12'(esum) || oovf[d] !== eovf) begin
          errors++; $display("FAIL rand_sum d=%0d got sum=%0d ovf=%b exp %0d %b", d, osum[d], oovf[d], esum, eovf);
        end
      end
    end
    clr[d] = 0; iv[d] = 0; ordy[d] = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_clear();
    test_overflow();
    test_count1();
    test_reset_mid();
    test_random(0, 400);
    test_random(1, 800);
    test_random(2, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
